// File: rtl/axi_mem_if.sv
// axi_mem_if: AXI read/write/snoop signal bundle between a master and axi_mem_responder.
interface axi_mem_if;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [63:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [63:0] m_axi_rdata;
  logic        m_axi_rlast;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [63:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_acvalid;
  logic        m_axi_acready;
  logic [63:0] m_axi_acaddr;
  logic [3:0]  m_axi_acsnoop;

  modport slave (
    input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_rready,
    input  m_axi_awvalid, m_axi_awaddr, m_axi_awlen,
    input  m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
    input  m_axi_bready, m_axi_acready,
    output m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rlast,
    output m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp,
    output m_axi_acvalid, m_axi_acaddr, m_axi_acsnoop
  );

  modport master (
    output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_rready,
    output m_axi_awvalid, m_axi_awaddr, m_axi_awlen,
    output m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
    output m_axi_bready, m_axi_acready,
    input  m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rlast,
    input  m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp,
    input  m_axi_acvalid, m_axi_acaddr, m_axi_acsnoop
  );
endinterface

// File: rtl/axi_mem_responder.sv
// axi_mem_responder: single-outstanding AXI INCR memory slave over a 64-bit word store.
// Optional feature: define AXI_RESP_SNOOP_EN to issue a MakeInvalid snoop after each write response.
module axi_mem_responder #(
  parameter int unsigned MEM_WORDS    = 4096,
  parameter int unsigned READ_LATENCY = 2
) (
  input logic      clk,
  input logic      reset,
  axi_mem_if.slave s_axi
);
  localparam int unsigned IDX_W    = $clog2(MEM_WORDS);
  localparam logic [7:0]  LAT_LAST = 8'((READ_LATENCY > 32'd1) ? (READ_LATENCY - 32'd2) : 32'd0);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_WAIT  = 3'd1;
  localparam logic [2:0] RD_BURST = 3'd2;
  localparam logic [2:0] WR_DATA  = 3'd3;
  localparam logic [2:0] WR_RESP  = 3'd4;
`ifdef AXI_RESP_SNOOP_EN
  localparam logic [2:0] SNOOP    = 3'd5;
`endif

  logic [63:0]      r_mem [MEM_WORDS];
  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [7:0]       r_cnt;
  logic [7:0]       r_len;
  logic [IDX_W-1:0] r_idx;
  logic             r_arready;
  logic             r_rvalid;
  logic [63:0]      r_rdata;
  logic             r_rlast;
  logic             r_wready;
  logic             r_bvalid;
  logic [1:0]       r_bresp;

  logic             w_ar_fire;
  logic             w_aw_fire;
  logic             w_r_fire;
  logic             w_w_fire;
  logic             w_b_fire;
  logic             w_rd_last;
  logic             w_wr_end;
  logic [IDX_W-1:0] w_ar_idx;
  logic [IDX_W-1:0] w_aw_idx;
  logic             w_unused;

  // AW is refused while AR is pending so a simultaneous pair never handshakes both.
  assign w_ar_fire = s_axi.m_axi_arvalid & r_arready;
  assign w_aw_fire = s_axi.m_axi_awvalid & r_arready & ~s_axi.m_axi_arvalid;
  assign w_r_fire  = r_rvalid & s_axi.m_axi_rready;
  assign w_w_fire  = s_axi.m_axi_wvalid & r_wready;
  assign w_b_fire  = r_bvalid & s_axi.m_axi_bready;
  assign w_rd_last = (r_cnt == r_len);
  assign w_wr_end  = s_axi.m_axi_wlast | (r_cnt == r_len);
  assign w_ar_idx  = s_axi.m_axi_araddr[3 +: IDX_W];
  assign w_aw_idx  = s_axi.m_axi_awaddr[3 +: IDX_W];

`ifdef AXI_RESP_SNOOP_EN
  logic        r_acvalid;
  logic [63:0] r_acaddr;
  logic [3:0]  r_acsnoop;
  logic [57:0] r_awline;
  logic        w_ac_fire;
  assign w_ac_fire = r_acvalid & s_axi.m_axi_acready;
  assign w_unused  = ^{s_axi.m_axi_araddr[63:IDX_W+3], s_axi.m_axi_araddr[2:0],
                       s_axi.m_axi_awaddr[2:0]};
`else
  assign w_unused  = ^{s_axi.m_axi_araddr[63:IDX_W+3], s_axi.m_axi_araddr[2:0],
                       s_axi.m_axi_awaddr[63:IDX_W+3], s_axi.m_axi_awaddr[2:0],
                       s_axi.m_axi_acready};
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode for one outstanding transaction.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_ar_fire)      w_state_nxt = (READ_LATENCY > 32'd1) ? RD_WAIT : RD_BURST;
        else if (w_aw_fire) w_state_nxt = WR_DATA;
      end
      RD_WAIT:  if (r_cnt == LAT_LAST)      w_state_nxt = RD_BURST;
      RD_BURST: if (w_r_fire && w_rd_last)  w_state_nxt = IDLE;
      WR_DATA:  if (w_w_fire && w_wr_end)   w_state_nxt = WR_RESP;
`ifdef AXI_RESP_SNOOP_EN
      WR_RESP:  if (w_b_fire)               w_state_nxt = SNOOP;
      SNOOP:    if (w_ac_fire)              w_state_nxt = IDLE;
`else
      WR_RESP:  if (w_b_fire)               w_state_nxt = IDLE;
`endif
      default:                              w_state_nxt = IDLE;
    endcase
  end

  // Registered handshake outputs, burst counters and read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rlast   <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_cnt     <= '0;
      r_len     <= '0;
      r_idx     <= '0;
`ifdef AXI_RESP_SNOOP_EN
      r_acvalid <= 1'b0;
      r_acaddr  <= '0;
      r_acsnoop <= '0;
      r_awline  <= '0;
`endif
    end else begin
      r_arready <= (w_state_nxt == IDLE);
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_ar_fire) begin
            r_idx <= w_ar_idx;
            r_len <= s_axi.m_axi_arlen;
            if (READ_LATENCY == 32'd1) begin
              r_rvalid <= 1'b1;
              r_rdata  <= r_mem[w_ar_idx];
              r_rlast  <= (s_axi.m_axi_arlen == 8'd0);
            end
          end else if (w_aw_fire) begin
            r_idx    <= w_aw_idx;
            r_len    <= s_axi.m_axi_awlen;
            r_wready <= 1'b1;
`ifdef AXI_RESP_SNOOP_EN
            r_awline <= s_axi.m_axi_awaddr[63:6];
`endif
          end
        end
        RD_WAIT: begin
          if (r_cnt == LAT_LAST) begin
            r_cnt    <= '0;
            r_rvalid <= 1'b1;
            r_rdata  <= r_mem[r_idx];
            r_rlast  <= (r_len == 8'd0);
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        RD_BURST: begin
          if (w_r_fire) begin
            if (w_rd_last) begin
              r_rvalid <= 1'b0;
              r_rlast  <= 1'b0;
              r_cnt    <= '0;
            end else begin
              r_cnt   <= r_cnt + 8'd1;
              r_idx   <= r_idx + IDX_W'(1);
              r_rdata <= r_mem[r_idx + IDX_W'(1)];
              r_rlast <= ((r_cnt + 8'd1) == r_len);
            end
          end
        end
        WR_DATA: begin
          if (w_w_fire) begin
            if (w_wr_end) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= (s_axi.m_axi_wlast != (r_cnt == r_len)) ? 2'b10 : 2'b00;
              r_cnt    <= '0;
            end else begin
              r_cnt <= r_cnt + 8'd1;
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        WR_RESP: begin
          if (w_b_fire) begin
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
`ifdef AXI_RESP_SNOOP_EN
            r_acvalid <= 1'b1;
            r_acaddr  <= {r_awline, 6'b0};
            r_acsnoop <= 4'b1101;
`endif
          end
        end
`ifdef AXI_RESP_SNOOP_EN
        SNOOP: begin
          if (w_ac_fire) begin
            r_acvalid <= 1'b0;
            r_acaddr  <= '0;
            r_acsnoop <= '0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Byte-enabled write into the backing store; contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && (r_state == WR_DATA) && w_w_fire) begin
      for (int b = 0; b < 8; b++) begin
        if (s_axi.m_axi_wstrb[b]) r_mem[r_idx][8*b +: 8] <= s_axi.m_axi_wdata[8*b +: 8];
      end
    end
  end

  assign s_axi.m_axi_arready = r_arready;
  assign s_axi.m_axi_awready = r_arready & ~s_axi.m_axi_arvalid;
  assign s_axi.m_axi_rvalid  = r_rvalid;
  assign s_axi.m_axi_rdata   = r_rdata;
  assign s_axi.m_axi_rlast   = r_rlast;
  assign s_axi.m_axi_wready  = r_wready;
  assign s_axi.m_axi_bvalid  = r_bvalid;
  assign s_axi.m_axi_bresp   = r_bresp;
`ifdef AXI_RESP_SNOOP_EN
  assign s_axi.m_axi_acvalid = r_acvalid;
  assign s_axi.m_axi_acaddr  = r_acaddr;
  assign s_axi.m_axi_acsnoop = r_acsnoop;
`else
  assign s_axi.m_axi_acvalid = 1'b0;
  assign s_axi.m_axi_acaddr  = '0;
  assign s_axi.m_axi_acsnoop = '0;
`endif
endmodule

// File: doc/axi_mem_responder.md
AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 Param MEM_WORDS, 4096, backing-store depth in 64-bit words (power of two).
REQ-002 Param READ_LATENCY, 2, cycles from AR handshake to first rvalid (min 1).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 m_axi_arvalid  input  1  read address valid.
REQ-006 m_axi_arready  output  1  read address accepted.
REQ-007 m_axi_araddr  input  64  read burst start byte address.
REQ-008 m_axi_arlen  input  8  read beats minus one.
REQ-009 m_axi_rvalid  output  1  read data valid.
REQ-010 m_axi_rready  input  1  master accepts read data.
REQ-011 m_axi_rdata  output  64  read beat data.
REQ-012 m_axi_rlast  output  1  final read beat.
REQ-013 m_axi_awvalid  input  1  write address valid.
REQ-014 m_axi_awready  output  1  write address accepted.
REQ-015 m_axi_awaddr  input  64  write burst start byte address.
REQ-016 m_axi_awlen  input  8  write beats minus one.
REQ-017 m_axi_wvalid  input  1  write data valid.
REQ-018 m_axi_wready  output  1  write data accepted.
REQ-019 m_axi_wdata  input  64  write beat data.
REQ-020 m_axi_wstrb  input  8  byte enables.
REQ-021 m_axi_wlast  input  1  final write beat.
REQ-022 m_axi_bvalid  output  1  write response valid.
REQ-023 m_axi_bready  input  1  master accepts response.
REQ-024 m_axi_bresp  output  2  00 OKAY, 10 SLVERR.
REQ-025 m_axi_acvalid  output  1  snoop request valid.
REQ-026 m_axi_acready  input  1  cache accepts snoop.
REQ-027 m_axi_acaddr  output  64  snoop line address.
REQ-028 m_axi_acsnoop  output  4  snoop type.

Function
REQ-029 FSM states: IDLE, RD_WAIT, RD_BURST, WR_DATA, WR_RESP, SNOOP; one transaction outstanding at a time.
REQ-030 arready and awready high only in IDLE; AR and AW valid together -> AR accepted, AW held off until next IDLE.
REQ-031 Word index = addr[3 +: log2(MEM_WORDS)], incremented per beat, wraps modulo MEM_WORDS; addr[2:0] ignored; bursts always INCR, 8 bytes/beat.
REQ-032 AR handshake -> RD_WAIT counts READ_LATENCY-1 cycles, then RD_BURST with rvalid=1 and rdata=mem[index] (first rvalid exactly READ_LATENCY cycles after handshake).
REQ-033 RD_BURST: rdata/rlast held stable while rvalid&!rready; beat advances on rvalid&rready; rlast=1 on beat arlen; handshake on last beat -> IDLE next cycle, rvalid=0.
REQ-034 AW handshake -> WR_DATA, wready=1; each wvalid&wready writes bytes of mem[index] where wstrb set, others unchanged.
REQ-035 Write burst ends on first beat with wlast=1 or beat count==awlen; if the two disagree, bresp=10, else 00; data still written.
REQ-036 WR_RESP: bvalid=1, bresp held until bready; then SNOOP (macro on) or IDLE.
REQ-037 Read of word written by a completed burst returns new data (write-then-read coherence, no bypass needed since single outstanding).

Reset
REQ-038 reset -> state IDLE, all valid/ready/last outputs 0, rdata 0, bresp 00, acaddr 0, acsnoop 0, counters 0; in-flight burst aborted, no B/R completion; memory contents retained.

Configuration
REQ-039 AXI_RESP_SNOOP_EN defined: after B handshake enter SNOOP, acvalid=1, acaddr={awaddr[63:6],6'b0}, acsnoop=4'b1101 (MakeInvalid), held until acready, then IDLE; one snoop per write burst.
REQ-040 AXI_RESP_SNOOP_EN undefined: SNOOP state absent, acvalid/acaddr/acsnoop constant 0, WR_RESP -> IDLE.

Verification
REQ-041 Write awaddr=0x100, awlen=3, data 0xA0..0xA3, wstrb=FF, then read araddr=0x100 arlen=3 -> rdata A0..A3, rlast on 4th beat, bresp 00.
REQ-042 READ_LATENCY=2, arlen=0, rready=1 -> rvalid exactly 2 cycles after AR handshake, one beat, rlast=1.
REQ-043 rready low 3 cycles mid-burst -> rdata/rlast unchanged, no beat skipped.
REQ-044 Word at 0x200 = 0xFFFF...FF, write 0x0 with wstrb=0x0F -> read gives 0xFFFFFFFF00000000; awlen=1 with wlast on beat 0 -> bresp 10.
REQ-045 arvalid and awvalid same cycle -> read completes first, write accepted after rlast handshake; reset mid read burst -> rvalid 0 next cycle, next AR served normally.
REQ-046 Macro on, write to 0x1238 -> after B handshake acvalid=1, acaddr=0x1200, acsnoop=1101, held 4 cycles with acready=0; macro off -> acvalid never asserted.
